// File: rtl/tt_sweep_checker_pkg.sv
// Shared types and helpers for the truth-table sweep checker.
package tt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Settle counter width; wide enough for SETTLE values up to 15.
  localparam int unsigned TW = 4;

  function automatic int unsigned num_vec(input int unsigned n_in);
    return 32'd1 << n_in;
  endfunction

endpackage

// File: rtl/tt_sweep_checker_if.sv
// Stimulus/response bundle between the sweep checker and its controller/gate.
interface tt_sweep_checker_if
  import tt_pkg::*;
#(
  parameter int unsigned N_IN = 2
) ();

  localparam int unsigned V = num_vec(N_IN);

  logic            start;
  logic [V-1:0]    expected;
  logic [N_IN-1:0] dut_in;
  logic            dut_out;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_count;
  logic [N_IN-1:0] first_err_idx;
  logic [V-1:0]    captured;

  modport master (
    output start, expected, dut_out,
    input  dut_in, busy, done, pass, err_count, first_err_idx, captured
  );

  modport slave (
    input  start, expected, dut_out,
    output dut_in, busy, done, pass, err_count, first_err_idx, captured
  );

endinterface

// File: rtl/tt_sweep_checker_settle_timer.sv
// Per-vector settle counter: counts 0..SETTLE and strobes on the sampling cycle.
module tt_settle_timer
  import tt_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic strobe_o
);

  logic [TW-1:0] timer_q;

  assign strobe_o = en_i && (timer_q == TW'(SETTLE));

  always_ff @(posedge clk) begin
    if (!rst_n || load_i) begin
      timer_q <= '0;
    end else if (en_i) begin
      timer_q <= strobe_o ? '0 : timer_q + TW'(1);
    end
  end

endmodule

// File: rtl/tt_sweep_checker.sv
// Sweeps all 2**N_IN input vectors of a gate, samples its output after a settle
// window and scores the samples against a latched truth table.
module tt_sweep_checker
  import tt_pkg::*;
#(
  parameter int unsigned N_IN   = 2,
  parameter int unsigned SETTLE = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  tt_sweep_checker_if.slave   bus
);

  localparam int unsigned V = num_vec(N_IN);

  state_e          state_q;
  logic [N_IN-1:0] idx_q;
  logic [V-1:0]    exp_q;
  logic [V-1:0]    cap_q;
  logic [N_IN:0]   err_q;
  logic [N_IN:0]   err_d;
  logic [N_IN-1:0] first_q;
  logic            busy_q;
  logic            done_q;
  logic            pass_q;

  logic accept;
  logic sample;
  logic mismatch;
  logic last;

  assign accept = bus.start && (state_q != RUN);

  tt_settle_timer #(
    .SETTLE (SETTLE)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (accept),
    .en_i     (state_q == RUN),
    .strobe_o (sample)
  );

  always_comb begin
    mismatch = 1'b0;
    err_d    = err_q;
    last     = &idx_q;
    mismatch = (bus.dut_out != exp_q[idx_q]);
    err_d    = err_q + (N_IN+1)'(mismatch);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      exp_q   <= '0;
      cap_q   <= '0;
      err_q   <= '0;
      first_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            state_q <= RUN;
            idx_q   <= '0;
            exp_q   <= bus.expected;
            cap_q   <= '0;
            err_q   <= '0;
            first_q <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
          end
        end
        RUN: begin
          if (sample) begin
            cap_q[idx_q] <= bus.dut_out;
            err_q        <= err_d;
            // Only the first mismatch of the sweep records its index.
            if (mismatch && (err_q == '0)) begin
              first_q <= idx_q;
            end
            if (last) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_d == '0);
            end else begin
              idx_q <= idx_q + N_IN'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.dut_in        = idx_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.pass          = pass_q;
  assign bus.err_count     = err_q;
  assign bus.first_err_idx = first_q;
  assign bus.captured      = cap_q;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Self-checking bench: two checkers (SETTLE=1 and SETTLE=0) driving table-defined gates.
module tb_tt_sweep_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tt_sweep_checker_if #(.N_IN(2)) ifa ();
  tt_sweep_checker_if #(.N_IN(2)) ifb ();

  tt_sweep_checker #(.N_IN(2), .SETTLE(1)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  tt_sweep_checker #(.N_IN(2), .SETTLE(0)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  int settle_of [2] = '{1, 0};

  logic       start_v [2];
  logic [3:0] exp_v   [2];
  logic [3:0] gate_v  [2];
  logic       done_v  [2];
  logic       busy_v  [2];
  logic       pass_v  [2];
  logic [2:0] err_v   [2];
  logic [1:0] first_v [2];
  logic [1:0] din_v   [2];
  logic [3:0] cap_v   [2];

  // Gate under test is an arbitrary 2-input truth table: output = gate[dut_in].
  assign ifa.start    = start_v[0];
  assign ifa.expected = exp_v[0];
  assign ifa.dut_out  = gate_v[0][ifa.dut_in];
  assign ifb.start    = start_v[1];
  assign ifb.expected = exp_v[1];
  assign ifb.dut_out  = gate_v[1][ifb.dut_in];

  assign done_v[0] = ifa.done;  assign done_v[1] = ifb.done;
  assign busy_v[0] = ifa.busy;  assign busy_v[1] = ifb.busy;
  assign pass_v[0] = ifa.pass;  assign pass_v[1] = ifb.pass;
  assign err_v[0]  = ifa.err_count;     assign err_v[1]  = ifb.err_count;
  assign first_v[0] = ifa.first_err_idx; assign first_v[1] = ifb.first_err_idx;
  assign din_v[0]  = ifa.dut_in;  assign din_v[1]  = ifb.dut_in;
  assign cap_v[0]  = ifa.captured; assign cap_v[1] = ifb.captured;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: captures equal the gate table; errors are the set bits of gate^expected.
  function automatic logic [13:0] model_done(input logic [3:0] exp, input logic [3:0] gate);
    logic [3:0] mism;
    int         cnt;
    int         first;
    mism  = gate ^ exp;
    cnt   = 0;
    first = -1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (mism[i]) begin
        cnt++;
        if (first < 0) first = int'(i);
      end
    end
    if (first < 0) first = 0;
    // {done, busy, pass, err_count, first_err_idx, dut_in, captured}
    return {1'b1, 1'b0, (cnt == 0), 3'(cnt), 2'(first), 2'd3, gate};
  endfunction

  function automatic logic [13:0] observed(input int k);
    return {done_v[k], busy_v[k], pass_v[k], err_v[k], first_v[k], din_v[k], cap_v[k]};
  endfunction

  // Starts one sweep, follows it to DONE and reports latency and dut_in trace errors.
  task automatic run_sweep(input int k, input logic [3:0] exp, input logic [3:0] gate,
                           input bit mid_pulse, output int lat, output int trace_bad);
    @(negedge clk);
    gate_v[k]  = gate;
    exp_v[k]   = exp;
    start_v[k] = 1'b1;
    @(negedge clk);
    start_v[k] = 1'b0;
    exp_v[k]   = 4'($urandom);
    lat = 0;
    trace_bad = 0;
    while (!done_v[k] && lat < 200) begin
      if (!busy_v[k] || din_v[k] != 2'(lat / (settle_of[k] + 1))) trace_bad++;
      start_v[k] = mid_pulse && (lat == 2);
      @(negedge clk);
      lat++;
    end
    start_v[k] = 1'b0;
    if (!done_v[k]) lat = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (observed(k) !== 14'd0) begin
        n_fail++;
        $display("FAIL reset_state[%0d]: got %h expected %h", k, observed(k), 14'd0);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_inverter();
    int lat, tb_bad;
    run_sweep(0, 4'b0011, 4'b0011, 1'b0, lat, tb_bad);
    n_checks++;
    if (lat !== 8) begin n_fail++; $display("FAIL inv_latency: got %0d expected %0d", lat, 8); end
    n_checks++;
    if (tb_bad !== 0) begin n_fail++; $display("FAIL inv_trace: got %0d bad cycles expected 0", tb_bad); end
    n_checks++;
    if (observed(0) !== model_done(4'b0011, 4'b0011)) begin
      n_fail++;
      $display("FAIL inv_pass_result: got %h expected %h", observed(0), model_done(4'b0011, 4'b0011));
    end
    @(negedge clk);
    n_checks++;
    if (done_v[0] !== 1'b1 || din_v[0] !== 2'd3) begin
      n_fail++;
      $display("FAIL inv_done_hold: got done=%b dut_in=%0d expected done=1 dut_in=3", done_v[0], din_v[0]);
    end
    run_sweep(0, 4'b0101, 4'b0011, 1'b0, lat, tb_bad);
    n_checks++;
    if (lat !== 8 || tb_bad !== 0) begin
      n_fail++;
      $display("FAIL inv_fail_timing: got lat=%0d bad=%0d expected lat=8 bad=0", lat, tb_bad);
    end
    n_checks++;
    if (observed(0) !== model_done(4'b0101, 4'b0011)) begin
      n_fail++;
      $display("FAIL inv_fail_result: got %h expected %h", observed(0), model_done(4'b0101, 4'b0011));
    end
  endtask

  task automatic test_and_settle0();
    int lat, tb_bad;
    run_sweep(1, 4'b1000, 4'b1000, 1'b1, lat, tb_bad);
    n_checks++;
    if (lat !== 4 || tb_bad !== 0) begin
      n_fail++;
      $display("FAIL and_timing: got lat=%0d bad=%0d expected lat=4 bad=0", lat, tb_bad);
    end
    n_checks++;
    if (observed(1) !== model_done(4'b1000, 4'b1000)) begin
      n_fail++;
      $display("FAIL and_result: got %h expected %h", observed(1), model_done(4'b1000, 4'b1000));
    end
  endtask

  task automatic test_reset_mid();
    int lat, tb_bad, wait_n;
    @(negedge clk);
    gate_v[0] = 4'b0011; exp_v[0] = 4'b0011; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_n = 0;
    while (din_v[0] != 2'd2 && wait_n < 20) begin @(negedge clk); wait_n++; end
    n_checks++;
    if (din_v[0] !== 2'd2) begin
      n_fail++;
      $display("FAIL rmid_reach_idx2: got dut_in=%0d expected 2", din_v[0]);
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (observed(0) !== 14'd0) begin
      n_fail++;
      $display("FAIL rmid_abort: got %h expected %h", observed(0), 14'd0);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (observed(0) !== 14'd0) begin
      n_fail++;
      $display("FAIL rmid_no_resume: got %h expected %h", observed(0), 14'd0);
    end
    run_sweep(0, 4'b0101, 4'b0011, 1'b0, lat, tb_bad);
    n_checks++;
    if (lat !== 8 || tb_bad !== 0 || observed(0) !== model_done(4'b0101, 4'b0011)) begin
      n_fail++;
      $display("FAIL rmid_clean_sweep: got lat=%0d bad=%0d res=%h expected lat=8 bad=0 res=%h",
               lat, tb_bad, observed(0), model_done(4'b0101, 4'b0011));
    end
  endtask

  task automatic test_back_to_back();
    int wait_n;
    @(negedge clk);
    gate_v[0] = 4'b1111; exp_v[0] = 4'b1111; start_v[0] = 1'b1;
    for (int sweep = 0; sweep < 2; sweep++) begin
      @(negedge clk);
      wait_n = 0;
      while (!done_v[0] && wait_n < 50) begin @(negedge clk); wait_n++; end
      n_checks++;
      if (done_v[0] !== 1'b1 || err_v[0] !== 3'd0 || pass_v[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_sweep%0d: got done=%b err=%0d pass=%b expected done=1 err=0 pass=1",
                 sweep, done_v[0], err_v[0], pass_v[0]);
      end
      if (sweep == 1) exp_v[0] = 4'b0000;
      @(negedge clk);
      n_checks++;
      if (done_v[0] !== 1'b0 || busy_v[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_restart%0d: got done=%b busy=%b expected done=0 busy=1",
                 sweep, done_v[0], busy_v[0]);
      end
    end
    start_v[0] = 1'b0;
    wait_n = 0;
    while (!done_v[0] && wait_n < 50) begin @(negedge clk); wait_n++; end
    n_checks++;
    if (observed(0) !== model_done(4'b0000, 4'b1111)) begin
      n_fail++;
      $display("FAIL b2b_all_wrong: got %h expected %h", observed(0), model_done(4'b0000, 4'b1111));
    end
  endtask

  task automatic test_random();
    int lat, tb_bad, k;
    logic [3:0] e, g;
    for (int n = 0; n < 16; n++) begin
      k = int'($urandom_range(0, 1));
      e = 4'($urandom);
      g = 4'($urandom);
      run_sweep(k, e, g, ($urandom_range(0, 1) == 1), lat, tb_bad);
      n_checks++;
      if (lat !== 4 * (settle_of[k] + 1) || tb_bad !== 0) begin
        n_fail++;
        $display("FAIL rand%0d_timing: inst=%0d got lat=%0d bad=%0d expected lat=%0d bad=0",
                 n, k, lat, tb_bad, 4 * (settle_of[k] + 1));
      end
      n_checks++;
      if (observed(k) !== model_done(e, g)) begin
        n_fail++;
        $display("FAIL rand%0d_result: inst=%0d exp=%b gate=%b got %h expected %h",
                 n, k, e, g, observed(k), model_done(e, g));
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      start_v[k] = 1'b0;
      exp_v[k]   = '0;
      gate_v[k]  = '0;
    end
    test_reset();
    test_inverter();
    test_and_settle0();
    test_reset_mid();
    test_back_to_back();
    test_random();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
